// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SRAM port between CPU and loader via req/ack; owns OE/WE timing.
// Define SRAM_ARB_RR_EN for round-robin arbitration; fixed CPU priority otherwise.
module sram_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              busy,
  output logic              grant_ldr
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_last_ldr;
  logic              r_started;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ldr_rdata;

  logic              w_pick_ldr;
  logic              w_sel_we;
  logic              w_grant;
  logic              w_last_beat;
  logic              w_oe;
  logic              w_we;
  logic              w_cpu_ack;
  logic              w_ldr_ack;

`ifdef SRAM_ARB_RR_EN
  // On a tie the port that did not win last time goes first.
  assign w_pick_ldr = ldr_req & (~cpu_req | ~r_last_ldr);
`else
  assign w_pick_ldr = ldr_req & ~cpu_req;
`endif

  assign w_sel_we    = w_pick_ldr ? ldr_we : cpu_we;
  assign w_grant     = (r_state == S_IDLE) & (cpu_req | ldr_req);
  assign w_last_beat = (r_state == S_ACCESS) & (r_cnt == CNT_W'(1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_oe      = 1'b0;
    w_we      = 1'b0;
    w_cpu_ack = 1'b0;
    w_ldr_ack = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req | ldr_req) begin
          w_next = w_sel_we ? S_SETUP : S_ACCESS;
        end
      end
      S_SETUP: begin
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_oe = ~r_we;
        w_we = r_we;
        if (r_cnt == CNT_W'(1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_cpu_ack = ~r_last_ldr;
        w_ldr_ack = r_last_ldr;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Fields are latched once at grant; requester changes afterwards are ignored.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_last_ldr  <= 1'b1;
      r_started   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_last_ldr <= w_pick_ldr;
        r_started  <= 1'b1;
        r_we       <= w_sel_we;
        r_addr     <= w_pick_ldr ? ldr_addr : cpu_addr;
        r_wdata    <= w_pick_ldr ? ldr_wdata : cpu_wdata;
        r_cnt      <= w_sel_we ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_last_beat & ~r_we) begin
        if (r_last_ldr) begin
          r_ldr_rdata <= sram_rdata;
        end else begin
          r_cpu_rdata <= sram_rdata;
        end
      end
    end
  end

  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign cpu_rdata  = r_cpu_rdata;
  assign ldr_rdata  = r_ldr_rdata;
  assign Mem_OE     = w_oe;
  assign Mem_WE     = w_we;
  assign cpu_ack    = w_cpu_ack;
  assign ldr_ack    = w_ldr_ack;
  assign busy       = (r_state != S_IDLE);
  // Reset leaves the pointer at the loader but reports the CPU until the first grant.
  assign grant_ldr  = r_last_ldr & r_started;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter: default timing instance plus RD_WAIT=1/WR_WAIT=3 instance.
`timescale 1ns/1ps
module tb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          ldr;
        bit          we;
        logic [15:0] rd;
        int          lat;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic        cpu_req0 = 0, cpu_we0 = 0, ldr_req0 = 0, ldr_we0 = 0;
    logic [19:0] cpu_addr0 = 0, ldr_addr0 = 0;
    logic [15:0] cpu_wdata0 = 0, ldr_wdata0 = 0;
    logic [15:0] cpu_rdata0, ldr_rdata0, sram_wdata0, sram_rdata0;
    logic [19:0] sram_addr0;
    logic        cpu_ack0, ldr_ack0, oe0, we0, busy0, gl0;

    logic        cpu_req1 = 0, cpu_we1 = 0, ldr_req1 = 0, ldr_we1 = 0;
    logic [19:0] cpu_addr1 = 0, ldr_addr1 = 0;
    logic [15:0] cpu_wdata1 = 0, ldr_wdata1 = 0;
    logic [15:0] cpu_rdata1, ldr_rdata1, sram_wdata1, sram_rdata1;
    logic [19:0] sram_addr1;
    logic        cpu_ack1, ldr_ack1, oe1, we1, busy1, gl1;

    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];

    sram_arbiter u0 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req0), .cpu_we(cpu_we0), .cpu_addr(cpu_addr0), .cpu_wdata(cpu_wdata0),
        .cpu_rdata(cpu_rdata0), .cpu_ack(cpu_ack0),
        .ldr_req(ldr_req0), .ldr_we(ldr_we0), .ldr_addr(ldr_addr0), .ldr_wdata(ldr_wdata0),
        .ldr_rdata(ldr_rdata0), .ldr_ack(ldr_ack0),
        .sram_addr(sram_addr0), .sram_wdata(sram_wdata0), .sram_rdata(sram_rdata0),
        .Mem_OE(oe0), .Mem_WE(we0), .busy(busy0), .grant_ldr(gl0)
    );

    sram_arbiter #(.RD_WAIT(1), .WR_WAIT(3)) u1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
        .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1),
        .ldr_req(ldr_req1), .ldr_we(ldr_we1), .ldr_addr(ldr_addr1), .ldr_wdata(ldr_wdata1),
        .ldr_rdata(ldr_rdata1), .ldr_ack(ldr_ack1),
        .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1),
        .Mem_OE(oe1), .Mem_WE(we1), .busy(busy1), .grant_ldr(gl1)
    );

    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) mem0[i] <= (i == 16) ? 16'h1234 : 16'h1000 + 16'(i);
        end else if (we0) begin
            mem0[sram_addr0[7:0]] <= sram_wdata0;
        end
    end
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) mem1[i] <= (i == 16) ? 16'h1234 : 16'h1000 + 16'(i);
        end else if (we1) begin
            mem1[sram_addr1[7:0]] <= sram_wdata1;
        end
    end
    assign sram_rdata0 = mem0[sram_addr0[7:0]];
    assign sram_rdata1 = mem1[sram_addr1[7:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        chk("oe_we_excl_u0", oe0 & we0, 1'b0);
        chk("oe_we_excl_u1", oe1 & we1, 1'b0);
    endtask

    task automatic txn0(input bit ldr, input bit we, input logic [19:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_rd);
        exp_t e;
        int   n;
        bit   got;
        e.ldr = ldr; e.we = we; e.rd = exp_rd; e.lat = we ? 4 : 3;
        sb.push_back(e);
        if (ldr) begin
            ldr_req0 = 1; ldr_we0 = we; ldr_addr0 = a; ldr_wdata0 = wd;
        end else begin
            cpu_req0 = 1; cpu_we0 = we; cpu_addr0 = a; cpu_wdata0 = wd;
        end
        n = 0; got = 0;
        while (!got && n < 16) begin
            step(); n++; got = cpu_ack0 | ldr_ack0;
        end
        cpu_req0 = 0; ldr_req0 = 0;
        chk("ack_seen", got, 1'b1);
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("ack_owner", {cpu_ack0, ldr_ack0}, e.ldr ? 2'b01 : 2'b10);
        chk("grant_ldr", gl0, e.ldr);
        if (!e.we) chk("rdata", e.ldr ? ldr_rdata0 : cpu_rdata0, e.rd);
        step();
    endtask

    task automatic txn1(input bit we, input logic [19:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input int exp_lat, input int exp_pulse);
        exp_t e;
        int   n;
        int   pulse;
        bit   got;
        e.ldr = 0; e.we = we; e.rd = exp_rd; e.lat = exp_lat;
        sb.push_back(e);
        cpu_req1 = 1; cpu_we1 = we; cpu_addr1 = a; cpu_wdata1 = wd;
        n = 0; pulse = 0; got = 0;
        while (!got && n < 16) begin
            step(); n++;
            if (oe1 | we1) pulse++;
            got = cpu_ack1 | ldr_ack1;
        end
        cpu_req1 = 0;
        chk("u1_ack_seen", got, 1'b1);
        e = sb.pop_front();
        chk("u1_latency", n, e.lat);
        chk("u1_strobe_cycles", pulse, exp_pulse);
        chk("u1_ack_owner", {cpu_ack1, ldr_ack1}, 2'b10);
        if (!e.we) chk("u1_rdata", cpu_rdata1, e.rd);
        step();
    endtask

    initial begin
        exp_t e;
        int   n;
        bit   got;

        step(); step();
        chk("rst_ctrl", {cpu_ack0, ldr_ack0, oe0, we0, busy0, gl0}, 6'b0);
        chk("rst_rdata", {cpu_rdata0, ldr_rdata0}, 32'h0);
        chk("rst_sram", {sram_addr0, sram_wdata0}, 36'h0);
        Reset = 0;
        step();

        chk("rd_idle_busy", busy0, 1'b0);
        e.ldr = 0; e.we = 0; e.rd = 16'h1234; e.lat = 3;
        sb.push_back(e);
        cpu_req0 = 1; cpu_we0 = 0; cpu_addr0 = 20'h00010;
        step();
        chk("rd_t1_oe", oe0, 1'b1);
        chk("rd_t1_busy", busy0, 1'b1);
        chk("rd_t1_addr", sram_addr0, 20'h00010);
        chk("rd_t1_ack", cpu_ack0, 1'b0);
        cpu_addr0 = 20'h00099;
        step();
        chk("rd_t2_oe", oe0, 1'b1);
        chk("rd_t2_addr", sram_addr0, 20'h00010);
        chk("rd_t2_ack", cpu_ack0, 1'b0);
        step();
        e = sb.pop_front();
        chk("rd_t3_acks", {cpu_ack0, ldr_ack0}, 2'b10);
        chk("rd_t3_oe", oe0, 1'b0);
        chk("rd_t3_rdata", cpu_rdata0, e.rd);
        cpu_req0 = 0;
        step();
        chk("rd_ack_pulse", cpu_ack0, 1'b0);
        chk("rd_idle_addr_hold", sram_addr0, 20'h00010);

        e.ldr = 1; e.we = 1; e.rd = 16'h0; e.lat = 4;
        sb.push_back(e);
        ldr_req0 = 1; ldr_we0 = 1; ldr_addr0 = 20'h00020; ldr_wdata0 = 16'hBEEF;
        step();
        chk("wr_t1_setup", {busy0, oe0, we0, ldr_ack0}, 4'b1000);
        step();
        chk("wr_t2_we", we0, 1'b1);
        chk("wr_t2_bus", {sram_addr0, sram_wdata0}, {20'h00020, 16'hBEEF});
        step();
        chk("wr_t3_we", we0, 1'b1);
        step();
        e = sb.pop_front();
        chk("wr_t4_acks", {cpu_ack0, ldr_ack0}, e.ldr ? 2'b01 : 2'b10);
        chk("wr_t4_we", we0, 1'b0);
        chk("wr_t4_grant", gl0, 1'b1);
        ldr_req0 = 0;
        step();
        chk("wr_grant_hold", gl0, 1'b1);
        chk("wr_no_rdata", ldr_rdata0, 16'h0);

        txn0(0, 0, 20'h00020, 16'h0, 16'hBEEF);
        txn0(1, 0, 20'h00010, 16'h0, 16'h1234);
        chk("cpu_rdata_hold", cpu_rdata0, 16'hBEEF);

        for (int i = 0; i < 4; i++) begin
            e.ldr = RR && (i % 2 == 1);
            e.we  = 0;
            e.rd  = e.ldr ? 16'hBEEF : 16'h1234;
            e.lat = 3 + 4 * i;
            sb.push_back(e);
        end
        cpu_req0 = 1; cpu_we0 = 0; cpu_addr0 = 20'h00010;
        ldr_req0 = 1; ldr_we0 = 0; ldr_addr0 = 20'h00020;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            while (!got && n < 40) begin
                step(); n++; got = cpu_ack0 | ldr_ack0;
            end
            chk("tie_ack_seen", got, 1'b1);
            e = sb.pop_front();
            chk("tie_latency", n, e.lat);
            chk("tie_owner", {cpu_ack0, ldr_ack0}, e.ldr ? 2'b01 : 2'b10);
            chk("tie_rdata", e.ldr ? ldr_rdata0 : cpu_rdata0, e.rd);
        end
        cpu_req0 = 0; ldr_req0 = 0;
        step();

        cpu_req0 = 1; cpu_we0 = 0; cpu_addr0 = 20'h00010;
        step();
        step();
        chk("abort_t2_oe", oe0, 1'b1);
        Reset = 1;
        step();
        chk("abort_ctrl", {oe0, busy0, cpu_ack0, gl0}, 4'b0);
        chk("abort_rdata", cpu_rdata0, 16'h0);
        Reset = 0; cpu_req0 = 0;
        step();
        chk("abort_no_ack", {cpu_ack0, busy0}, 2'b00);
        txn0(0, 0, 20'h00010, 16'h0, 16'h1234);

        txn1(1, 20'h00030, 16'hCAFE, 16'h0, 5, 3);
        txn1(0, 20'h00030, 16'h0, 16'hCAFE, 2, 1);
        chk("u1_idle", {busy1, gl1, ldr_ack1}, 3'b000);
        chk("u1_ldr_rdata", ldr_rdata1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
